sipo_pingpong_buffer: RTL and testbench

Successor to the single-port SIPO register bank. It collects IWIDTH-bit words, written one at a time by explicit address, into NCHANNELS vectors of NINPUTS words each. Words go into a ping-pong pair of banks, so one bank can fill while the other is presented in parallel to the vector compute stage. Both the write side and the read side use valid/ready handshakes. Per-word written masks detect when a frame is complete.

---
 rtl/sipo_pingpong_buffer.sv | 104 ++++++++++
 tb/tb_sipo_pingpong_buffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_pingpong_buffer.sv
// Ping-pong SIPO buffer: addressed word writes fill one bank while the
// other bank is presented to the consumer as a parallel frame.
module sipo_pingpong_buffer #(
   parameter int IWIDTH    = 10,
   parameter int NINPUTS   = 8,
   parameter int NCHANNELS = 2,
   parameter int AW        = $clog2(NINPUTS),
   parameter int CW        = (NCHANNELS > 1) ? $clog2(NCHANNELS) : 1,
   parameter int FW        = $clog2(NINPUTS*NCHANNELS+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW-1:0]     in_ch,
   input  logic [AW-1:0]     in_addr,
   input  logic [IWIDTH-1:0] in_data,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IWIDTH-1:0] out [NCHANNELS][NINPUTS],
   output logic              wr_err,
   output logic [FW-1:0]     fill_count
);

   localparam int NW = NINPUTS*NCHANNELS;

   logic [IWIDTH-1:0] mem [2][NCHANNELS][NINPUTS];
   logic [NW-1:0]     mask [2];
   logic [1:0]        full;
   logic              wr_sel;
   logic              rd_sel;

   logic              in_range;
   logic              acc;
   logic              bad;
   logic              pop;
   logic              is_new;
   logic              done;
   logic [NW-1:0]     bitv;
   logic [NW-1:0]     nmask;

   assign out_valid = full[rd_sel];

   always_comb begin
      in_range = (int'(in_ch) < NCHANNELS) && (int'(in_addr) < NINPUTS);
      in_ready = !full[wr_sel] && !clear;
      acc      = in_valid && in_ready && in_range;
      bad      = in_valid && in_ready && !in_range;
      pop      = out_valid && out_ready;
      bitv     = '0;
      if (in_range)
         bitv = NW'(1) << (int'(in_ch)*NINPUTS + int'(in_addr));
      is_new   = (mask[wr_sel] & bitv) == '0;
      nmask    = mask[wr_sel] | bitv;
      done     = acc && (&nmask);
   end

   always_comb
      for (int c = 0; c < NCHANNELS; c++)
         for (int i = 0; i < NINPUTS; i++)
            out[c][i] = mem[rd_sel][c][i];

   // Pop and fill always target different banks, so their updates never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < NCHANNELS; c++)
               for (int i = 0; i < NINPUTS; i++)
                  mem[b][c][i] <= '0;
         mask[0]    <= '0;
         mask[1]    <= '0;
         full       <= '0;
         wr_sel     <= 1'b0;
         rd_sel     <= 1'b0;
         wr_err     <= 1'b0;
         fill_count <= '0;
      end else begin
         wr_err <= bad;
         if (pop) begin
            full[rd_sel] <= 1'b0;
            mask[rd_sel] <= '0;
            rd_sel       <= !rd_sel;
         end
         if (acc) begin
            mem[wr_sel][in_ch][in_addr] <= in_data;
            mask[wr_sel] <= nmask;
            if (done) begin
               full[wr_sel] <= 1'b1;
               wr_sel       <= !wr_sel;
               fill_count   <= '0;
            end else if (is_new) begin
               fill_count <= fill_count + FW'(1);
            end
         end
         if (clear) begin
            if (!full[wr_sel])
               mask[wr_sel] <= '0;
            fill_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_pingpong_buffer.sv
// Bench for sipo_pingpong_buffer: frame-queue reference model, vector
// table on a 6-word instance, and directed ping-pong corner cases.
`timescale 1ns/1ps
module tb_sipo_pingpong_buffer;

   localparam int IW  = 10;
   localparam int NIN = 8;
   localparam int NCH = 2;
   localparam int NW  = NIN*NCH;
   localparam int AW  = 3;
   localparam int CW  = 1;
   localparam int FW  = 5;
   localparam int N6  = 6;
   localparam int FW6 = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, clear, out_valid, out_ready, wr_err;
   logic [CW-1:0] in_ch;
   logic [AW-1:0] in_addr;
   logic [IW-1:0] in_data;
   logic [IW-1:0] out [NCH][NIN];
   logic [FW-1:0] fill_count;

   logic           v6, ir6, clr6, ov6, or6, err6;
   logic [CW-1:0]  ch6;
   logic [2:0]     a6;
   logic [IW-1:0]  d6;
   logic [IW-1:0]  out6 [NCH][N6];
   logic [FW6-1:0] fill6;

   sipo_pingpong_buffer #(.IWIDTH(IW), .NINPUTS(NIN), .NCHANNELS(NCH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .in_addr(in_addr), .in_data(in_data),
      .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .wr_err(wr_err), .fill_count(fill_count)
   );

   sipo_pingpong_buffer #(.IWIDTH(IW), .NINPUTS(N6), .NCHANNELS(NCH)) dut6 (
      .clk(clk), .rst(rst),
      .in_valid(v6), .in_ready(ir6),
      .in_ch(ch6), .in_addr(a6), .in_data(d6),
      .clear(clr6),
      .out_valid(ov6), .out_ready(or6), .out(out6),
      .wr_err(err6), .fill_count(fill6)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: queue of completed frames plus the partial frame.
   typedef logic [NW*IW-1:0] frame_t;
   frame_t        fq[$];
   frame_t        pd;
   logic [NW-1:0] pm;
   logic          m_err;

   typedef struct {
      logic v; int ch; int addr; int d; logic clr;
      logic ir; int fill; logic err;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_frame(input string nm, input frame_t got,
                            input frame_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic frame_t dut_frame();
      frame_t f;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < NIN; i++)
            f[(c*NIN+i)*IW +: IW] = out[c][i];
      return f;
   endfunction

   function automatic logic m_ready(input logic clr);
      return (fq.size() < 2) && !clr;
   endfunction

   task automatic model_edge(input logic v, input int ch, input int addr,
                             input int d, input logic clr, input logic ordy);
      logic rdy, inr, pop;
      int   j;
      rdy   = m_ready(clr);
      inr   = (ch < NCH) && (addr < NIN);
      pop   = (fq.size() > 0) && ordy;
      m_err = v && rdy && !inr;
      if (pop) void'(fq.pop_front());
      if (v && rdy && inr) begin
         j = ch*NIN + addr;
         pd[j*IW +: IW] = IW'(d);
         pm[j] = 1'b1;
         if (&pm) begin
            fq.push_back(pd);
            pm = '0;
         end
      end
      if (clr) pm = '0;
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic cyc(input logic v, input int ch, input int addr,
                      input int d, input logic clr, input logic ordy);
      in_valid  = v;
      in_ch     = CW'(ch);
      in_addr   = AW'(addr);
      in_data   = IW'(d);
      clear     = clr;
      out_ready = ordy;
      #2;
      chk("in_ready", in_ready, m_ready(clr));
      @(posedge clk);
      model_edge(v, ch, addr, d, clr, ordy);
      #1;
      chk("out_valid", out_valid, fq.size() > 0);
      chk("fill_count", fill_count, $countones(pm));
      chk("wr_err", wr_err, m_err);
      if (fq.size() > 0) chk_frame("out", dut_frame(), fq[0]);
   endtask

   task automatic t6(input vec_t r, input int idx);
      v6   = r.v;
      ch6  = CW'(r.ch);
      a6   = 3'(r.addr);
      d6   = IW'(r.d);
      clr6 = r.clr;
      or6  = 1'b0;
      #2;
      chk($sformatf("t6[%0d].in_ready", idx), ir6, r.ir);
      @(posedge clk);
      #1;
      chk($sformatf("t6[%0d].fill", idx), fill6, r.fill);
      chk($sformatf("t6[%0d].wr_err", idx), err6, r.err);
      chk($sformatf("t6[%0d].out_valid", idx), ov6, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 0, 7,  1, 1'b0, 1'b1, 0, 1'b1};
      tbl[1]  = '{1'b0, 0, 0,  0, 1'b0, 1'b1, 0, 1'b0};
      tbl[2]  = '{1'b1, 0, 0, 10, 1'b0, 1'b1, 1, 1'b0};
      tbl[3]  = '{1'b1, 1, 6, 11, 1'b0, 1'b1, 1, 1'b1};
      tbl[4]  = '{1'b1, 1, 5, 12, 1'b0, 1'b1, 2, 1'b0};
      tbl[5]  = '{1'b1, 0, 0, 13, 1'b0, 1'b1, 2, 1'b0};
      tbl[6]  = '{1'b1, 0, 1, 14, 1'b0, 1'b1, 3, 1'b0};
      tbl[7]  = '{1'b1, 0, 2, 15, 1'b0, 1'b1, 4, 1'b0};
      tbl[8]  = '{1'b1, 0, 3, 16, 1'b0, 1'b1, 5, 1'b0};
      tbl[9]  = '{1'b0, 0, 0,  0, 1'b1, 1'b0, 0, 1'b0};
      tbl[10] = '{1'b1, 0, 3, 17, 1'b1, 1'b0, 0, 1'b0};
      tbl[11] = '{1'b1, 1, 7, 18, 1'b1, 1'b0, 0, 1'b0};
      tbl[12] = '{1'b0, 0, 0,  0, 1'b0, 1'b1, 0, 1'b0};

      rst = 1'b1;
      in_valid = 0; in_ch = '0; in_addr = '0; in_data = '0;
      clear = 0; out_ready = 0;
      v6 = 0; ch6 = '0; a6 = '0; d6 = '0; clr6 = 0; or6 = 0;
      pd = '0; pm = '0; m_err = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      chk("reset.out_valid", out_valid, 1'b0);
      chk("reset.wr_err", wr_err, 1'b0);
      chk("reset.fill", fill_count, 0);
      chk("reset.in_ready", in_ready, 1'b1);
      chk_frame("reset.out", dut_frame(), '0);
      chk("reset6.in_ready", ir6, 1'b1);
      chk("reset6.fill", fill6, 0);

      // Out-of-range, rewrite and clear on the 6-word instance.
      for (int r = 0; r < 13; r++) t6(tbl[r], r);

      // After the clear a frame needs exactly 12 fresh writes.
      for (int k = 0; k < 12; k++) begin
         v6 = 1'b1; ch6 = CW'(k/6); a6 = 3'(k%6); d6 = IW'(50+k); clr6 = 0;
         @(posedge clk);
         #1;
         chk("n6.fill", fill6, (k == 11) ? 0 : k+1);
         chk("n6.out_valid", ov6, k == 11);
      end
      v6 = 1'b0;
      chk("n6.out[1][5]", out6[1][5], 61);
      chk("n6.out[0][0]", out6[0][0], 50);
      or6 = 1'b1;
      @(posedge clk);
      #1;
      or6 = 1'b0;
      chk("n6.pop", ov6, 1'b0);

      // Single frame, scrambled address order.
      for (int k = 0; k < 16; k++) begin
         int j;
         j = (k*5 + 3) % 16;
         chk("sf.pre_valid", out_valid, 1'b0);
         cyc(1, j/8, j%8, (j/8)*16 + j%8, 0, 0);
         chk("sf.fill", fill_count, (k == 15) ? 0 : k+1);
         chk("sf.valid", out_valid, k == 15);
      end
      chk("sf.out[1][7]", out[1][7], 23);
      chk("sf.out[0][3]", out[0][3], 3);
      cyc(0, 0, 0, 0, 0, 1);

      // Ping-pong: two frames with the consumer stalled.
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 16; k++)
            cyc(1, k/8, k%8, 100*(f+1) + k, 0, 0);
      chk("pp.in_ready", in_ready, 1'b0);
      for (int n = 0; n < 3; n++) begin
         cyc(1, 0, 0, 300, 0, 0);
         chk("pp.held_ready", in_ready, 1'b0);
         chk("pp.held_fill", fill_count, 0);
         chk("pp.out[0][0]", out[0][0], 100);
         chk("pp.out[1][7]", out[1][7], 115);
      end
      cyc(1, 0, 0, 300, 0, 1);
      chk("pp.pop_valid", out_valid, 1'b1);
      chk("pp.pop_out[0][0]", out[0][0], 200);
      chk("pp.pop_out[1][7]", out[1][7], 215);
      chk("pp.pop_ready", in_ready, 1'b1);
      cyc(1, 0, 0, 300, 0, 0);
      chk("pp.fill_after", fill_count, 1);

      // Frame completion and pop on the same edge.
      for (int k = 1; k < 16; k++)
         cyc(1, k/8, k%8, 300 + k, 0, k == 15);
      chk("cc.valid", out_valid, 1'b1);
      chk("cc.out[0][0]", out[0][0], 300);
      chk("cc.out[0][1]", out[0][1], 301);
      chk("cc.out[1][7]", out[1][7], 315);
      cyc(0, 0, 0, 0, 0, 1);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++)
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1023),
             $urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0);
      while (fq.size() > 0) cyc(0, 0, 0, 0, 0, 1);

      // One full bank plus a partial one, then an asynchronous reset.
      for (int k = 0; k < 19; k++)
         cyc(1, (k%16)/8, k%8, 400 + k, 0, 0);
      chk("ar.pre_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("ar.valid_async", out_valid, 1'b0);
      chk("ar.fill_async", fill_count, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      fq.delete();
      pm = '0;
      m_err = 1'b0;
      @(posedge clk);
      #1;
      chk("ar.in_ready", in_ready, 1'b1);
      chk("ar.valid", out_valid, 1'b0);
      chk("ar.fill", fill_count, 0);
      chk_frame("ar.out", dut_frame(), '0);
      for (int k = 0; k < 16; k++)
         cyc(1, k/8, k%8, 500 + k, 0, 0);
      chk("ar.refill_valid", out_valid, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
